// File: rtl/comp_reduce.sv
// comp_reduce: streaming signed max/min reduction returning the winning value and its index
module comp_reduce #(
  parameter int LEN   = 9,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN-1:0]   in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-1:0]   out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_ovf
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  localparam logic [IDX_W:0] FULL = {1'b1, {IDX_W{1'b0}}};
  state_t         state, state_nx;
  logic [IDX_W:0] cnt;
  logic           mode_q, take, better, full;
  assign in_ready  = state != HOLD;
  assign out_valid = state == HOLD;
  assign take      = in_valid && in_ready;
  assign full      = cnt == FULL;
  assign better    = mode_q ? ($signed(in_data) < $signed(out_data))
                            : ($signed(in_data) > $signed(out_data));
  always_comb begin
    state_nx = state;
    state_nx = (state == HOLD) ? (out_ready ? IDLE : HOLD)
             : take ? (in_last ? HOLD : ACC) : state;
  end
  // cnt is the index the next accepted beat will occupy; once it reaches FULL the index pins at all-ones
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      out_data <= '0;
      out_idx  <= '0;
      out_ovf  <= 1'b0;
      cnt      <= '0;
      mode_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (take && state == IDLE) begin
        out_data <= in_data;
        out_idx  <= '0;
        cnt      <= (IDX_W+1)'(1);
        out_ovf  <= 1'b0;
        mode_q   <= mode;
      end else if (take) begin
        if (better) begin
          out_data <= in_data;
          out_idx  <= full ? '1 : cnt[IDX_W-1:0];
        end
        if (full) out_ovf <= 1'b1;
        else cnt <= cnt + 1'b1;
      end
    end
endmodule
